// File: rtl/display_pkg.sv
// display_pkg: shared state encoding and control codes for the text-mode buffer controller.
package display_pkg;

   typedef enum logic [2:0] {
      CLEAR,
      IDLE,
      SCROLL_RD,
      SCROLL_WR,
      SCROLL_FILL
   } tb_state_t;

   localparam logic [7:0] CHAR_BS = 8'h08;
   localparam logic [7:0] CHAR_LF = 8'h0A;
   localparam logic [7:0] CHAR_CR = 8'h0D;

endpackage

// File: rtl/cursor_blink.sv
// cursor_blink: blink phase for the cursor overlay, restartable on activity.
// Only compiled when CURSOR_BLINK_EN is defined.
`ifdef CURSOR_BLINK_EN
module cursor_blink #(
   parameter int unsigned BLINK_LOG2 = 24
) (
   input  logic Clk,
   input  logic Reset_N,
   input  logic Restart,
   input  logic Enable,
   output logic Visible
);

   logic [BLINK_LOG2-1:0] count;

   // Phase flips when the counter wraps; frozen while Enable is low.
   always_ff @(posedge Clk or negedge Reset_N) begin
      if (!Reset_N) begin
         count   <= '0;
         Visible <= 1'b1;
      end else if (Restart) begin
         count   <= '0;
         Visible <= 1'b1;
      end else if (Enable) begin
         count <= count + BLINK_LOG2'(1);
         if (&count)
            Visible <= ~Visible;
      end
   end

endmodule
`endif

// File: rtl/text_buffer_ctrl.sv
// text_buffer_ctrl: write-side controller for port B of the text-mode character RAM.
// Define CURSOR_BLINK_EN to blink the cursor overlay; otherwise it is steady in IDLE.
module text_buffer_ctrl
   import display_pkg::*;
#(
   parameter int unsigned       COLS       = 80,
   parameter int unsigned       ROWS       = 30,
   parameter int unsigned       CHAR_W     = 8,
   parameter logic [CHAR_W-1:0] BLANK      = '0,
   parameter int unsigned       BLINK_LOG2 = 24,
   localparam int unsigned      ADDR_W     = $clog2(COLS*ROWS)
) (
   input  logic              Clk,
   input  logic              Reset_N,
   input  logic              CharWE,
   input  logic [CHAR_W-1:0] CharIn,
   input  logic              AddressWE,
   input  logic [ADDR_W-1:0] AddressIn,
   input  logic              ClearReq,
   output logic              Ready,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [CHAR_W-1:0] MemWrData,
   output logic              MemWE,
   input  logic [CHAR_W-1:0] MemRdData,
   output logic [ADDR_W-1:0] CursorAddr,
   output logic              CursorVisible
);

   localparam int unsigned       CELLS     = COLS*ROWS;
   localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
   localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS-1);
   localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'((ROWS-1)*COLS);
   localparam logic [ADDR_W-1:0] LAST_COPY = ADDR_W'(CELLS-COLS-1);
   localparam logic [ADDR_W:0]   CELLS_W   = (ADDR_W+1)'(CELLS);

   tb_state_t         state;
   logic [ADDR_W-1:0] index;
   logic [ADDR_W-1:0] rowStart;
   logic [ADDR_W:0]   cursorInc;
   logic [7:0]        code;
   logic              doClear, doMove, doChar;
   logic              isBs, isLf, isCr, isPrint, scrollGo;

   // Row start by comparison against row boundaries, avoiding a divider.
   function automatic logic [ADDR_W-1:0] rowStartOf(input logic [ADDR_W-1:0] a);
      rowStartOf = '0;
      for (int r = 1; r < int'(ROWS); r++)
         if (a >= ADDR_W'(r*COLS))
            rowStartOf = ADDR_W'(r*COLS);
   endfunction

   assign Ready     = (state == IDLE);
   assign code      = CharIn[7:0];
   assign cursorInc = {1'b0, CursorAddr} + (ADDR_W+1)'(1);

   // Request arbitration: clear beats move beats character.
   always_comb begin
      doClear = 1'b0;
      doMove  = 1'b0;
      doChar  = 1'b0;
      if (Ready) begin
         if (ClearReq)
            doClear = 1'b1;
         else if (AddressWE)
            doMove = ({1'b0, AddressIn} < CELLS_W);
         else
            doChar = CharWE;
      end
   end

   assign isBs     = doChar && (code == CHAR_BS);
   assign isLf     = doChar && (code == CHAR_LF);
   assign isCr     = doChar && (code == CHAR_CR);
   assign isPrint  = doChar && !(code == CHAR_BS || code == CHAR_LF || code == CHAR_CR);
   assign scrollGo = (isLf && rowStart == LAST_ROW) || (isPrint && cursorInc == CELLS_W);

   always_ff @(posedge Clk or negedge Reset_N) begin
      if (!Reset_N) begin
         state      <= CLEAR;
         index      <= '0;
         CursorAddr <= '0;
         rowStart   <= '0;
      end else begin
         case (state)
            CLEAR: begin
               CursorAddr <= '0;
               rowStart   <= '0;
               if (index == LAST_CELL) begin
                  state <= IDLE;
                  index <= '0;
               end else
                  index <= index + ONE;
            end
            IDLE: begin
               if (doClear) begin
                  state <= CLEAR;
                  index <= '0;
               end else if (scrollGo) begin
                  state      <= (ROWS > 1) ? SCROLL_RD : SCROLL_FILL;
                  index      <= '0;
                  CursorAddr <= LAST_ROW;
                  rowStart   <= LAST_ROW;
               end else if (doMove) begin
                  CursorAddr <= AddressIn;
                  rowStart   <= rowStartOf(AddressIn);
               end else if (isBs && CursorAddr != '0) begin
                  CursorAddr <= CursorAddr - ONE;
                  if (CursorAddr == rowStart)
                     rowStart <= rowStart - COLS_A;
               end else if (isLf) begin
                  CursorAddr <= rowStart + COLS_A;
                  rowStart   <= rowStart + COLS_A;
               end else if (isCr) begin
                  CursorAddr <= rowStart;
               end else if (isPrint) begin
                  CursorAddr <= ADDR_W'(cursorInc);
                  if (ADDR_W'(cursorInc) == rowStart + COLS_A)
                     rowStart <= rowStart + COLS_A;
               end
            end
            SCROLL_RD: state <= SCROLL_WR;
            SCROLL_WR: begin
               if (index == LAST_COPY) begin
                  state <= SCROLL_FILL;
                  index <= LAST_ROW;
               end else begin
                  state <= SCROLL_RD;
                  index <= index + ONE;
               end
            end
            SCROLL_FILL: begin
               if (index == LAST_CELL) begin
                  state <= IDLE;
                  index <= '0;
               end else
                  index <= index + ONE;
            end
            default: begin
               state <= CLEAR;
               index <= '0;
            end
         endcase
      end
   end

   // Port B drive; IDLE writes follow the accepted strobe in the same cycle.
   always_comb begin
      MemWE     = 1'b0;
      MemAddr   = index;
      MemWrData = BLANK;
      case (state)
         CLEAR:     MemWE = Reset_N;
         IDLE: begin
            if (isBs && CursorAddr != '0) begin
               MemWE   = 1'b1;
               MemAddr = CursorAddr - ONE;
            end else if (isPrint) begin
               MemWE     = 1'b1;
               MemAddr   = CursorAddr;
               MemWrData = CharIn;
            end
         end
         SCROLL_RD: MemAddr = index + COLS_A;
         SCROLL_WR: begin
            MemWE     = 1'b1;
            MemWrData = MemRdData;
         end
         SCROLL_FILL: MemWE = 1'b1;
         default: MemWE = 1'b0;
      endcase
   end

`ifdef CURSOR_BLINK_EN
   logic blinkOn;

   cursor_blink #(
      .BLINK_LOG2(BLINK_LOG2)
   ) blink (
      .Clk     (Clk),
      .Reset_N (Reset_N),
      .Restart (doMove | doChar),
      .Enable  (Ready),
      .Visible (blinkOn)
   );

   assign CursorVisible = Ready & blinkOn;
`else
   assign CursorVisible = Ready;
`endif

endmodule
